rst_seq: RTL and testbench

//  CPU reset sequencer. Takes the external asynchronous board reset, synchronizes
//  its release, stretches it, then releases memory-side reset before core reset.
//  Its outputs drive the rst lines seen by the CPU testbench reset interface and
//  the DUT. A software reset request from RUN replays the stretch/release sequence.

---
 rtl/rst_seq_pkg.sv | 26 ++
 rtl/rst_seq_if.sv | 33 +++
 rtl/rst_seq_sync.sv | 26 ++
 rtl/rst_seq.sv | 137 +++++++++++++
 tb/tb_rst_seq.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types for the CPU reset sequencer.
//   rst_state_t : sequencer phase (assert / stretch / memory released / run)
//   rst_cause_t : reason for the most recent reset
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    STRETCH = 2'd1,
    REL_MEM = 2'd2,
    RUN     = 2'd3
  } rst_state_t;

  typedef enum logic [1:0] {
    RC_NONE = 2'd0,
    RC_EXT  = 2'd1,
    RC_SW   = 2'd2
  } rst_cause_t;

  // Width needed to count up to the longer of the two timed phases.
  function automatic int cnt_width(input int stretch_cycles, input int m2c_cycles);
    int top_v;
    top_v = (stretch_cycles > m2c_cycles) ? stretch_cycles : m2c_cycles;
    return (top_v < 1) ? 1 : $clog2(top_v + 1);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Reset-sequencer signal bundle.
//   sw_rst_req : software reset request into the sequencer
//   mem_rst    : active-high reset for memory/bus side
//   core_rst   : active-high reset for the CPU core
//   rst_done   : both resets released, sequencer running
//   rst_cause  : cause of the last reset
// Modport master is the sequencer; slave is the consumer of the resets.
interface rst_seq_if;
  import rst_seq_pkg::*;

  logic       sw_rst_req;
  logic       mem_rst;
  logic       core_rst;
  logic       rst_done;
  rst_cause_t rst_cause;

  modport master (
    input  sw_rst_req,
    output mem_rst,
    output core_rst,
    output rst_done,
    output rst_cause
  );

  modport slave (
    output sw_rst_req,
    input  mem_rst,
    input  core_rst,
    input  rst_done,
    input  rst_cause
  );

endinterface

// File: rtl/rst_seq_sync.sv
// Async-assert / sync-release reset synchronizer.
//   clk      : destination clock
//   rst      : asynchronous active-low reset, clears the whole chain at once
//   rst_sync : high once STAGES rising edges have passed with rst high
module rst_seq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);

  logic [STAGES-1:0] chain_r;

  // Shift ones in after release; any rst low clears all stages immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = chain_r[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// CPU reset sequencer top.
//   clk  : system clock
//   rst  : asynchronous active-low board reset
//   bus  : rst_seq_if.master (sw_rst_req in; mem_rst, core_rst, rst_done,
//          rst_cause out)
// After the synchronized release of rst, mem_rst is held for STRETCH_CYCLES
// edges, then core_rst for MEM_TO_CORE_CYCLES more. A software request seen in
// RUN replays the stretch/release sequence without touching the synchronizer.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int STRETCH_CYCLES     = 16,
  parameter int MEM_TO_CORE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  rst_seq_if.master  bus
);

  localparam int CNT_W = cnt_width(STRETCH_CYCLES, MEM_TO_CORE_CYCLES);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] M2C_LAST     = CNT_W'(MEM_TO_CORE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic             rst_sync_s;
  rst_state_t       state_r;
  rst_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             mem_rst_r;
  logic             core_rst_r;
  logic             rst_done_r;
  rst_cause_t       rst_cause_r;
  logic             mem_rst_nxt_s;
  logic             core_rst_nxt_s;
  logic             rst_done_nxt_s;
  rst_cause_t       rst_cause_nxt_s;

  rst_seq_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (rst_sync_s)
  );

  // State and phase counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ASSERT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic; the counter restarts at each phase entry.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ASSERT: begin
        if (rst_sync_s) begin
          state_nxt_s = STRETCH;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ASSERT;
        end
      end
      STRETCH: begin
        if (cnt_r == STRETCH_LAST) begin
          state_nxt_s = REL_MEM;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      REL_MEM: begin
        if (cnt_r == M2C_LAST) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        if (bus.sw_rst_req) begin
          state_nxt_s = STRETCH;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = ASSERT;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Output values derived from the phase being entered, so the registered
  // outputs change on the same edge as the transition.
  always_comb begin
    mem_rst_nxt_s   = (state_nxt_s == ASSERT) || (state_nxt_s == STRETCH);
    core_rst_nxt_s  = (state_nxt_s != RUN);
    rst_done_nxt_s  = (state_nxt_s == RUN);
    rst_cause_nxt_s = rst_cause_r;
    if ((state_r == RUN) && bus.sw_rst_req) begin
      rst_cause_nxt_s = RC_SW;
    end else begin
      rst_cause_nxt_s = rst_cause_r;
    end
  end

  // Output registers; board reset asserts everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rst_r   <= 1'b1;
      core_rst_r  <= 1'b1;
      rst_done_r  <= 1'b0;
      rst_cause_r <= RC_EXT;
    end else begin
      mem_rst_r   <= mem_rst_nxt_s;
      core_rst_r  <= core_rst_nxt_s;
      rst_done_r  <= rst_done_nxt_s;
      rst_cause_r <= rst_cause_nxt_s;
    end
  end

  assign bus.mem_rst   = mem_rst_r;
  assign bus.core_rst  = core_rst_r;
  assign bus.rst_done  = rst_done_r;
  assign bus.rst_cause = rst_cause_r;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: two instances (default timing and 3/1/1 timing) share
// clk and rst. Expected outputs come from a timeline model: the number of
// edges since rst release and the edge at which the current stretch started.
module tb_rst_seq;

  logic clk;
  logic rst;
  logic sw;

  int n_total;
  int n_pass;

  // Model state: edges since release (-1 = none yet), stretch anchor, cause.
  int n;
  int anc   [2];
  int cause [2];
  int p_ss  [2];
  int p_st  [2];
  int p_m2c [2];

  rst_seq_if ifc0 ();
  rst_seq_if ifc1 ();

  rst_seq u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifc0.master)
  );

  rst_seq #(
    .SYNC_STAGES        (3),
    .STRETCH_CYCLES     (1),
    .MEM_TO_CORE_CYCLES (1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1.master)
  );

  // 10-unit system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, n);
  endtask

  task automatic model_reset();
    n = -1;
    for (int d = 0; d < 2; d++) begin
      anc[d]   = p_ss[d];
      cause[d] = 1;
    end
  endtask

  // Called at each rising edge with rst high.
  task automatic model_edge();
    logic running [2];
    for (int d = 0; d < 2; d++) running[d] = (n >= anc[d] + p_st[d] + p_m2c[d]);
    n = n + 1;
    for (int d = 0; d < 2; d++) begin
      if (running[d] && sw) begin
        anc[d]   = n;
        cause[d] = 2;
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [1:0] e_mem, e_core, e_done, e_cause;
    logic [1:0] o_mem, o_core, o_done, o_cause;
    for (int d = 0; d < 2; d++) begin
      e_mem   = {1'b0, !(n >= anc[d] + p_st[d])};
      e_done  = {1'b0, (n >= anc[d] + p_st[d] + p_m2c[d])};
      e_core  = {1'b0, !e_done[0]};
      e_cause = 2'(cause[d]);
      if (d == 0) begin
        o_mem = {1'b0, ifc0.mem_rst}; o_core = {1'b0, ifc0.core_rst};
        o_done = {1'b0, ifc0.rst_done}; o_cause = ifc0.rst_cause;
      end else begin
        o_mem = {1'b0, ifc1.mem_rst}; o_core = {1'b0, ifc1.core_rst};
        o_done = {1'b0, ifc1.rst_done}; o_cause = ifc1.rst_cause;
      end
      chk($sformatf("%s.d%0d.mem_rst", ph, d), o_mem, e_mem);
      chk($sformatf("%s.d%0d.core_rst", ph, d), o_core, e_core);
      chk($sformatf("%s.d%0d.rst_done", ph, d), o_done, e_done);
      chk($sformatf("%s.d%0d.rst_cause", ph, d), o_cause, e_cause);
      chk($sformatf("%s.d%0d.core_before_mem", ph, d),
          {1'b0, (!o_core[0] && o_mem[0])}, 2'd0);
    end
  endtask

  // One clock: drive sw, model the edge, check on the falling edge.
  task automatic cyc(input logic swv, input string ph);
    sw = swv;
    ifc0.sw_rst_req = swv;
    ifc1.sw_rst_req = swv;
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check_all(ph);
  endtask

  // Drop rst for 3 time units between edges (called right after a falling edge).
  task automatic glitch(input string ph);
    sw = 1'b0;
    ifc0.sw_rst_req = 1'b0;
    ifc1.sw_rst_req = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    #1 check_all(ph);
    #2 rst = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    p_ss[0] = 2;  p_st[0] = 16; p_m2c[0] = 8;
    p_ss[1] = 3;  p_st[1] = 1;  p_m2c[1] = 1;
    sw = 1'b0;
    ifc0.sw_rst_req = 1'b0;
    ifc1.sw_rst_req = 1'b0;
    rst = 1'b1;
    model_reset();

    // Power-on: rst low for 5 cycles, values must appear without a clock edge.
    #1 rst = 1'b0;
    #2 check_all("por");
    repeat (5) cyc(1'b0, "rst_low");

    // External release: default 18/26, small instance 4/5.
    #3 rst = 1'b1;
    repeat (30) cyc(1'b0, "ext_seq");

    // Single-cycle software request in RUN.
    cyc(1'b1, "sw_pulse");
    repeat (30) cyc(1'b0, "sw_seq");

    // Requests during STRETCH and REL_MEM are ignored by the default instance.
    glitch("restart3");
    for (int i = 0; i < 26; i++) cyc(((i % 3) == 1) ? 1'b1 : 1'b0, "sw_ignored");
    repeat (6) cyc(1'b0, "sw_ignored_tail");

    // Board reset dropped between edges while in REL_MEM.
    glitch("restart4");
    repeat (22) cyc(1'b0, "to_rel_mem");
    glitch("drop_rel_mem");
    repeat (30) cyc(1'b0, "after_drop");

    // Short glitch while in RUN after a software sequence.
    cyc(1'b1, "sw_before_glitch");
    repeat (30) cyc(1'b0, "sw_seq2");
    glitch("glitch_run");
    repeat (30) cyc(1'b0, "after_glitch");

    // Request held high: re-triggers each time RUN is re-entered.
    repeat (60) cyc(1'b1, "sw_held");
    repeat (30) cyc(1'b0, "sw_held_tail");

    // Randomized requests with occasional board-reset glitches.
    for (int r = 0; r < 8; r++) begin
      int len;
      len = int'($urandom_range(20, 70));
      for (int i = 0; i < len; i++) cyc(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, "rand");
      glitch("rand_glitch");
    end
    repeat (30) cyc(1'b0, "final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
